lcd_byte_sequencer: RTL

- Sits directly upstream of the 4-bit LCD nibble controller (Spartan-3E character LCD path).
- After reset, runs the HD44780 power-on nibble init sequence.
- Then accepts whole command/data bytes from the user logic over a ready/valid handshake.
- Splits each byte into high/low nibbles, hands each nibble to the controller over a request/ack handshake, and enforces the post-command execution delay.

---
 rtl/lcd_byte_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_byte_sequencer.sv
// lcd_byte_sequencer
//   Front end for the 4-bit HD44780 nibble controller. After reset it plays
//   the power-on init nibbles (3,3,3,2) with their settle delays. It then
//   accepts whole command/data bytes, sends each byte as a high nibble and a
//   low nibble, and waits out the command execution time before taking the
//   next byte.
//
// Ports
//   clk           system clock
//   iReset        synchronous active-high reset
//   iData/iRS     byte to send and its register select (0 = command)
//   iWrite        byte valid
//   oReady        sequencer can accept a byte
//   oInitDone     init sequence complete, held until reset
//   oNibble       nibble to the controller
//   oNibbleRS     register select for oNibble
//   oNibbleWrite  nibble request to the controller
//   iNibbleAck    controller has consumed the nibble
//
// Handshakes
//   Byte side: a byte moves on a rising edge where iWrite && oReady. oReady
//   is high only in IDLE and drops the cycle after the accept; iWrite while
//   oReady is low is ignored. Nibble side: oNibbleWrite stays high, with
//   oNibble/oNibbleRS stable, until iNibbleAck is sampled high; it drops the
//   following cycle. iNibbleAck outside a request is ignored and there is no
//   timeout.
module lcd_byte_sequencer #(
  parameter int unsigned INIT_WAIT  = 750000,
  parameter int unsigned INIT_DLY0  = 205000,
  parameter int unsigned INIT_DLY1  = 5000,
  parameter int unsigned CMD_WAIT   = 2000,
  parameter int unsigned CLEAR_WAIT = 82000,
  parameter int unsigned NIBBLE_GAP = 50
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iWrite,
  output logic       oReady,
  output logic       oInitDone,
  output logic [3:0] oNibble,
  output logic       oNibbleRS,
  output logic       oNibbleWrite,
  input  logic       iNibbleAck
);

  typedef enum logic [2:0] {
    S_INIT_WAIT = 3'd0,
    S_INIT_REQ  = 3'd1,
    S_INIT_DLY  = 3'd2,
    S_IDLE      = 3'd3,
    S_HI_REQ    = 3'd4,
    S_GAP       = 3'd5,
    S_LO_REQ    = 3'd6,
    S_POST      = 3'd7
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [19:0] cnt;
  logic [19:0] wait_len;
  logic        wait_done;
  logic        in_wait;
  logic [1:0]  init_idx;
  logic [1:0]  init_idx_next;
  logic        init_done;
  logic [7:0]  byte_q;
  logic        rs_q;
  logic        clear_cmd;
  logic [3:0]  nibble_q;
  logic        nibble_rs_q;

  // Clear display / return home need the long execution time.
  assign clear_cmd = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);

  assign in_wait = (state == S_INIT_WAIT) || (state == S_INIT_DLY) ||
                   (state == S_GAP) || (state == S_POST);

  always_comb begin
    wait_len = 20'd1;
    case (state)
      S_INIT_WAIT: wait_len = 20'(INIT_WAIT);
      S_INIT_DLY: begin
        case (init_idx)
          2'd0:    wait_len = 20'(INIT_DLY0);
          2'd1:    wait_len = 20'(INIT_DLY1);
          default: wait_len = 20'(CMD_WAIT);
        endcase
      end
      S_GAP:   wait_len = 20'(NIBBLE_GAP);
      S_POST:  wait_len = clear_cmd ? 20'(CLEAR_WAIT) : 20'(CMD_WAIT);
      default: wait_len = 20'd1;
    endcase
  end

  // Counter runs 0..N-1 inside a wait state, so the state lasts N cycles.
  assign wait_done = in_wait && (cnt == wait_len - 20'd1);

  // The index advances as INIT_DLY finishes; the nibble register is loaded
  // on entry to INIT_REQ, so it must look at the advanced value.
  assign init_idx_next = (state == S_INIT_DLY) ? init_idx + 2'd1 : init_idx;

  // State register
  always_ff @(posedge clk) begin
    if (iReset) state <= S_INIT_WAIT;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_INIT_WAIT: if (wait_done) state_next = S_INIT_REQ;
      S_INIT_REQ:  if (iNibbleAck) state_next = S_INIT_DLY;
      S_INIT_DLY:  if (wait_done) state_next = (init_idx == 2'd3) ? S_IDLE : S_INIT_REQ;
      S_IDLE:      if (iWrite) state_next = S_HI_REQ;
      S_HI_REQ:    if (iNibbleAck) state_next = S_GAP;
      S_GAP:       if (wait_done) state_next = S_LO_REQ;
      S_LO_REQ:    if (iNibbleAck) state_next = S_POST;
      S_POST:      if (wait_done) state_next = S_IDLE;
      default:     state_next = S_INIT_WAIT;
    endcase
  end

  // Output logic
  always_comb begin
    oReady       = (state == S_IDLE);
    oNibbleWrite = (state == S_INIT_REQ) || (state == S_HI_REQ) || (state == S_LO_REQ);
    oInitDone    = init_done;
    oNibble      = nibble_q;
    oNibbleRS    = nibble_rs_q;
  end

  // Datapath: delay counter, init index, byte latch, nibble register
  always_ff @(posedge clk) begin
    if (iReset) begin
      cnt         <= 20'd0;
      init_idx    <= 2'd0;
      init_done   <= 1'b0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      nibble_q    <= 4'h0;
      nibble_rs_q <= 1'b0;
    end else begin
      if (state_next != state) cnt <= 20'd0;
      else if (in_wait)        cnt <= cnt + 20'd1;

      if (state == S_INIT_DLY && wait_done) begin
        init_idx <= init_idx + 2'd1;
        if (init_idx == 2'd3) init_done <= 1'b1;
      end

      if (state == S_IDLE && iWrite) begin
        byte_q <= iData;
        rs_q   <= iRS;
      end

      // Load only on entry to a request state so the nibble stays stable
      // while the request is outstanding, whatever iData does meanwhile.
      if (state_next != state) begin
        case (state_next)
          S_INIT_REQ: begin
            nibble_q    <= (init_idx_next == 2'd3) ? 4'h2 : 4'h3;
            nibble_rs_q <= 1'b0;
          end
          S_HI_REQ: begin
            nibble_q    <= iData[7:4];
            nibble_rs_q <= iRS;
          end
          S_LO_REQ: begin
            nibble_q    <= byte_q[3:0];
            nibble_rs_q <= rs_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
